fib_sequencer: RTL
==================

# fib_sequencer

- Sequential controller that drives the shared 4-bit combinational ALU to generate Fibonacci terms F(0)..F(n-1).
- Acts as the initiator on the ALU operand/opcode interface: it presents operands and opcode, and consumes the ALU result and zero flag in the same cycle.
- Uses the ALU for both the term additions and the remaining-count decrement, so the ALU zero flag terminates the run.
- Sits between the top-level start/count controls and the display/term consumer.

## Interface
- WIDTH, 4: data width of operands, result, count and term.
- OP_ADD, 3'b000: ALU opcode for A+B (WIDTH-1 bits wide).
- OP_SUB, 3'b001: ALU opcode for A-B (WIDTH-1 bits wide).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- n  in  WIDTH  number of terms to emit; captured when start is accepted.
- alu_a  out  WIDTH  ALU operand 1.
- alu_b  out  WIDTH  ALU operand 2.
- alu_op  out  WIDTH-1  ALU opcode.
- alu_out  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_zero  in  1  ALU zero flag (alu_out == 0).
- busy  out  1  high in every state except IDLE.
- term_valid  out  1  one-cycle strobe; term is valid while it is high.
- term  out  WIDTH  current Fibonacci term; holds its last value between strobes.
- done  out  1  one-cycle pulse at the end of a run.
- overflow  out  1  sticky; some emitted term differs from its true value mod 2^WIDTH.

## Operation
Registers:
- prev, curr (WIDTH bits).
- rem (WIDTH bits).
- prev_wr, curr_wr: wrap-taint bits.

States: IDLE, EMIT, DEC, ADD, DONE.

- **IDLE**
  - When start=1: rem<=n, prev<=0, curr<=1, prev_wr<=0, curr_wr<=0, overflow<=0.
  - Next state is EMIT if n!=0, otherwise DONE.
- **EMIT**
  - term_valid=1, term<=prev, overflow<=overflow|prev_wr.
  - Next state: DEC.
- **DEC**
  - Drive alu_a=rem, alu_b=1, alu_op=OP_SUB; rem<=alu_out.
  - Next state is DONE if alu_zero=1, otherwise ADD.
- **ADD**
  - Drive alu_a=prev, alu_b=curr, alu_op=OP_ADD.
  - prev<=curr, prev_wr<=curr_wr, curr<=alu_out.
  - curr_wr<=prev_wr|curr_wr|(alu_out<curr).
  - Next state: EMIT.
- **DONE**
  - done=1 for one cycle; next state: IDLE.

ALU drive outside DEC/ADD: alu_a=0, alu_b=0, alu_op=OP_ADD.

Arithmetic: all values unsigned mod 2^WIDTH. Wrap is detected only by unsigned compare of alu_out against curr. The ALU carry is not used.

Boundary conditions:
- n=0: no term_valid; done pulses one cycle after start is accepted.
- start while busy: ignored. n changes while busy: ignored.
- start held high through DONE: a new run is accepted in the first IDLE cycle after DONE.
- rst_n low at any time, including mid-run:
  - immediately forces IDLE;
  - clears all registers and outputs to 0;
  - drives alu_op=OP_ADD;
  - no done pulse is produced.
- A tainted intermediate (computed after a wrap) is flagged only when it is emitted.

## Timing
- Reset values: busy=0, term_valid=0, term=0, done=0, overflow=0, alu_a=0, alu_b=0, alu_op=OP_ADD.
- Outputs are registered state decodes. alu_a/alu_b/alu_op are combinational from state, prev, curr, rem.
- Cycle numbering: start is sampled at edge 0 and cycle k follows edge k.
- term_valid is high in cycles 1, 4, 7, …, 1+3(n-1); one term every 3 cycles.
- done is high in cycle 3n for n>=1, and in cycle 1 for n=0.
- busy rises in cycle 1 and falls after the DONE cycle.
- Minimum start-to-start spacing is 3n+1 cycles (n>=1).

## Test plan
- **n=5, start pulse:** term 0,1,1,2,3 at cycles 1,4,7,10,13; done at cycle 15; overflow=0; busy high in cycles 1..15.
- **n=0:** done at cycle 1; term_valid never asserted; term stays 0.
- **n=1:** single term 0 at cycle 1; DEC drives alu_a=1, alu_b=1, alu_op=3'b001 in cycle 2; done at cycle 3.
- **n=8 then n=9:**
  - n=8: terms 0,1,1,2,3,5,8,13 with overflow=0 at done.
  - n=9: ninth term 5 (21 mod 16); overflow rises in the cycle after that emit and holds until the next accepted start.
- **Interference:** start re-pulsed during run (n=3) has no effect; terms 0,1,1 and done at cycle 9. Then rst_n low in cycle 5 of an n=6 run: all outputs 0 immediately, no done, and the next start restarts from term 0.
- **n=15:** 15 strobes, done at cycle 45, final term 377 mod 16 = 9, overflow=1.

Source files
------------

// File: rtl/fib_sequencer.sv
// Fibonacci term generator that borrows the shared 4-bit ALU for both the
// term additions and the remaining-count decrement; the ALU zero flag ends a run.
module fib_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [WIDTH-2:0] alu_op_o,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic             alu_zero_i,
    output logic             busy_o,
    output logic             term_valid_o,
    output logic [WIDTH-1:0] term_o,
    output logic             done_o,
    output logic             overflow_o
);

    localparam logic [WIDTH-2:0] OP_ADD = '0;
    localparam logic [WIDTH-2:0] OP_SUB = (WIDTH-1)'(1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        DEC,
        ADD,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] curr_q, curr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             prev_wr_q, prev_wr_d;
    logic             curr_wr_q, curr_wr_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, term_valid_q, done_q;

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = OP_ADD;
        case (state_q)
            DEC: begin
                alu_a_o  = rem_q;
                alu_b_o  = ONE;
                alu_op_o = OP_SUB;
            end
            ADD: begin
                alu_a_o  = prev_q;
                alu_b_o  = curr_q;
                alu_op_o = OP_ADD;
            end
            default: ;
        endcase
    end

    // The term register is loaded on entry to EMIT so it is already valid
    // during the strobe cycle; the value loaded is the upcoming prev.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        curr_d     = curr_q;
        rem_d      = rem_q;
        prev_wr_d  = prev_wr_q;
        curr_wr_d  = curr_wr_q;
        term_d     = term_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d      = n_i;
                    prev_d     = '0;
                    curr_d     = ONE;
                    prev_wr_d  = 1'b0;
                    curr_wr_d  = 1'b0;
                    overflow_d = 1'b0;
                    if (n_i != '0) begin
                        state_d = EMIT;
                        term_d  = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                overflow_d = overflow_q | prev_wr_q;
                state_d    = DEC;
            end
            DEC: begin
                rem_d   = alu_out_i;
                state_d = alu_zero_i ? DONE : ADD;
            end
            ADD: begin
                prev_d    = curr_q;
                prev_wr_d = curr_wr_q;
                curr_d    = alu_out_i;
                curr_wr_d = prev_wr_q | curr_wr_q | (alu_out_i < curr_q);
                term_d    = curr_q;
                state_d   = EMIT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            curr_q       <= '0;
            rem_q        <= '0;
            prev_wr_q    <= 1'b0;
            curr_wr_q    <= 1'b0;
            term_q       <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            term_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            curr_q       <= curr_d;
            rem_q        <= rem_d;
            prev_wr_q    <= prev_wr_d;
            curr_wr_q    <= curr_wr_d;
            term_q       <= term_d;
            overflow_q   <= overflow_d;
            busy_q       <= (state_d != IDLE);
            term_valid_q <= (state_d == EMIT);
            done_q       <= (state_d == DONE);
        end
    end

    assign busy_o       = busy_q;
    assign term_valid_o = term_valid_q;
    assign term_o       = term_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;

endmodule
